// File: rtl/rvx_dual_port_ram_responder_pkg.sv
// rvx_dual_port_ram_responder_pkg: shared sequencer encodings and access record for the RVX RAM responder.
package rvx_dual_port_ram_responder_pkg;
    localparam logic [1:0] PORT_IDLE    = 2'd0;
    localparam logic [1:0] PORT_WAIT    = 2'd1;
    localparam logic [1:0] PORT_RESPOND = 2'd2;
    typedef struct packed {
        logic [31:0] address;
        logic [31:0] wdata;
        logic [3:0]  wstrobe;
        logic        read;
        logic        write;
    } ram_access_t;
endpackage

// File: rtl/rvx_dual_port_ram_responder_if.sv
// rvx_dual_port_ram_responder_if: RVX instruction and data bus signals between core (master) and RAM (slave).
interface rvx_dual_port_ram_responder_if;
    logic [31:0] ibus_address;
    logic        ibus_rrequest;
    logic [31:0] ibus_rdata;
    logic        ibus_rresponse;
    logic [31:0] dbus_address;
    logic        dbus_rrequest;
    logic        dbus_wrequest;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_wstrobe;
    logic [31:0] dbus_rdata;
    logic        dbus_rresponse;
    logic        dbus_wresponse;
    modport master (
        output ibus_address, ibus_rrequest, dbus_address, dbus_rrequest, dbus_wrequest, dbus_wdata, dbus_wstrobe,
        input  ibus_rdata, ibus_rresponse, dbus_rdata, dbus_rresponse, dbus_wresponse
    );
    modport slave (
        input  ibus_address, ibus_rrequest, dbus_address, dbus_rrequest, dbus_wrequest, dbus_wdata, dbus_wstrobe,
        output ibus_rdata, ibus_rresponse, dbus_rdata, dbus_rresponse, dbus_wresponse
    );
endinterface

// File: rtl/rvx_ram_responder_port.sv
// rvx_ram_responder_port: per-port wait-state sequencer; commit names the access performed at this edge.
module rvx_ram_responder_port
    import rvx_dual_port_ram_responder_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  ram_access_t request,
    output ram_access_t commit,
    output logic        rresponse,
    output logic        wresponse
);
    ram_access_t held;
    logic [1:0]  state;
    logic [3:0]  count;
    logic        ready;
    logic        accept;
    logic        finishing;

    always_comb begin
        ready = (state == PORT_WAIT) ? (count == 4'd1) : 1'b1;
        accept = ready && (request.read || request.write);
        finishing = (state == PORT_WAIT) && (count == 4'd1);
        commit = '0;
        // Zero wait states access the array at the accept edge with the live request.
        if (!reset && (WAIT_STATES == 0) && accept) commit = request;
        if (!reset && (WAIT_STATES != 0) && finishing) commit = held;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= PORT_IDLE;
            count <= '0;
            held <= '0;
            rresponse <= 1'b0;
            wresponse <= 1'b0;
        end else begin
            rresponse <= commit.read;
            wresponse <= commit.write;
            if (accept) begin
                held <= request;
                state <= (WAIT_STATES == 0) ? PORT_RESPOND : PORT_WAIT;
                count <= 4'(WAIT_STATES);
            end else if (state == PORT_WAIT) begin
                count <= count - 4'd1;
                state <= (count == 4'd1) ? PORT_RESPOND : PORT_WAIT;
            end else begin
                state <= PORT_IDLE;
            end
        end
    end
endmodule

// File: rtl/rvx_dual_port_ram_responder.sv
// rvx_dual_port_ram_responder: word RAM serving RVX ibus fetches and dbus loads/stores with configurable wait states.
module rvx_dual_port_ram_responder
  import rvx_dual_port_ram_responder_pkg::*;
#(
  parameter int    MEMORY_SIZE      = 8192,
  parameter int    WAIT_STATES      = 0,
  parameter string MEMORY_INIT_FILE = ""
) (
  input  logic                         clock,
  input  logic                         reset,
  rvx_dual_port_ram_responder_if.slave bus,
  output logic                         access_error
);
  localparam int AW = $clog2(MEMORY_SIZE);
  logic [31:0] memory [MEMORY_SIZE/4];
  ram_access_t ibus_request;
  ram_access_t dbus_request;
  ram_access_t ibus_commit;
  ram_access_t dbus_commit;
  logic [AW-3:0] ibus_index;
  logic [AW-3:0] dbus_index;
  logic ibus_bad;
  logic dbus_bad;
  logic ibus_wresponse;
  logic port_unused;
  logic [31:0] ibus_rdata;
  logic [31:0] dbus_rdata;
  assign ibus_request = '{bus.ibus_address, 32'd0, 4'd0, bus.ibus_rrequest, 1'b0};
  assign dbus_request = '{bus.dbus_address, bus.dbus_wdata, bus.dbus_wstrobe, bus.dbus_rrequest, bus.dbus_wrequest};
  rvx_ram_responder_port #(.WAIT_STATES(WAIT_STATES)) ibus_port (
    .clock, .reset, .request(ibus_request), .commit(ibus_commit),
    .rresponse(bus.ibus_rresponse), .wresponse(ibus_wresponse)
  );
  rvx_ram_responder_port #(.WAIT_STATES(WAIT_STATES)) dbus_port (
    .clock, .reset, .request(dbus_request), .commit(dbus_commit),
    .rresponse(bus.dbus_rresponse), .wresponse(bus.dbus_wresponse)
  );
  assign ibus_index = ibus_commit.address[AW-1:2];
  assign dbus_index = dbus_commit.address[AW-1:2];
  assign port_unused = ^{ibus_commit.address, dbus_commit.address, ibus_commit.wdata,
                         ibus_commit.wstrobe, ibus_commit.write, ibus_wresponse};
`ifdef RVX_RAM_RESPONDER_RANGE_CHECK_EN
  assign ibus_bad = ibus_commit.address >= 32'(MEMORY_SIZE);
  assign dbus_bad = dbus_commit.address >= 32'(MEMORY_SIZE);
  always_ff @(posedge clock) begin
    if (reset)
      access_error <= 1'b0;
    else if ((ibus_commit.read && ibus_bad) || ((dbus_commit.read || dbus_commit.write) && dbus_bad))
      access_error <= 1'b1;
  end
`else
  assign ibus_bad = 1'b0;
  assign dbus_bad = 1'b0;
  assign access_error = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (dbus_commit.write && !dbus_bad)
      for (int i = 0; i < 4; i++)
        if (dbus_commit.wstrobe[i]) memory[dbus_index][8*i +: 8] <= dbus_commit.wdata[8*i +: 8];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      ibus_rdata <= '0;
      dbus_rdata <= '0;
    end else begin
      if (ibus_commit.read) ibus_rdata <= ibus_bad ? 32'd0 : memory[ibus_index];
      if (dbus_commit.read) dbus_rdata <= dbus_bad ? 32'd0 : memory[dbus_index];
    end
  end
  assign bus.ibus_rdata = ibus_rdata;
  assign bus.dbus_rdata = dbus_rdata;
endmodule

// File: tb/tb_rvx_dual_port_ram_responder.sv
// tb_rvx_dual_port_ram_responder: directed checks of the RAM responder at 0, 3 and 2 wait states.
module tb_rvx_dual_port_ram_responder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ae0, ae3, ae2;
    int errors = 0;
    int checks = 0;
    int n;

    always #5 clock = ~clock;

    rvx_dual_port_ram_responder_if b0 ();
    rvx_dual_port_ram_responder_if b3 ();
    rvx_dual_port_ram_responder_if b2 ();

    rvx_dual_port_ram_responder #(.MEMORY_SIZE(8192), .WAIT_STATES(0)) u0 (.clock(clock), .reset(reset), .bus(b0), .access_error(ae0));
    rvx_dual_port_ram_responder #(.MEMORY_SIZE(8192), .WAIT_STATES(3)) u3 (.clock(clock), .reset(reset), .bus(b3), .access_error(ae3));
    rvx_dual_port_ram_responder #(.MEMORY_SIZE(8192), .WAIT_STATES(2)) u2 (.clock(clock), .reset(reset), .bus(b2), .access_error(ae2));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic d0_op(input logic ir, input logic [31:0] iaddr, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strobe);
        b0.ibus_rrequest = ir;
        b0.ibus_address = iaddr;
        b0.dbus_rrequest = rd;
        b0.dbus_wrequest = wr;
        b0.dbus_address = addr;
        b0.dbus_wdata = wdata;
        b0.dbus_wstrobe = strobe;
        tick();
        b0.ibus_rrequest = 1'b0;
        b0.dbus_rrequest = 1'b0;
        b0.dbus_wrequest = 1'b0;
    endtask

    initial begin
        {b0.ibus_rrequest, b0.dbus_rrequest, b0.dbus_wrequest} = '0;
        {b3.ibus_rrequest, b3.dbus_rrequest, b3.dbus_wrequest} = '0;
        {b2.ibus_rrequest, b2.dbus_rrequest, b2.dbus_wrequest} = '0;
        {b0.ibus_address, b0.dbus_address, b0.dbus_wdata, b0.dbus_wstrobe} = '0;
        {b3.ibus_address, b3.dbus_address, b3.dbus_wdata, b3.dbus_wstrobe} = '0;
        {b2.ibus_address, b2.dbus_address, b2.dbus_wdata, b2.dbus_wstrobe} = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_irsp", 32'(b0.ibus_rresponse), 0);
        check("rst_irdata", b0.ibus_rdata, 0);
        check("rst_drsp", 32'(b0.dbus_rresponse), 0);
        check("rst_dwsp", 32'(b0.dbus_wresponse), 0);
        check("rst_drdata", b0.dbus_rdata, 0);
        check("rst_err", 32'(ae0), 0);

        d0_op(0, 0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        check("w_resp", 32'(b0.dbus_wresponse), 1);
        tick();
        check("w_pulse", 32'(b0.dbus_wresponse), 0);
        d0_op(1, 32'h10, 1, 0, 32'h10, 0, 0);
        check("r_drsp", 32'(b0.dbus_rresponse), 1);
        check("r_drdata", b0.dbus_rdata, 32'hDEADBEEF);
        check("r_irsp", 32'(b0.ibus_rresponse), 1);
        check("r_irdata", b0.ibus_rdata, 32'hDEADBEEF);
        tick();
        check("r_pulse", 32'(b0.dbus_rresponse), 0);
        check("r_hold", b0.dbus_rdata, 32'hDEADBEEF);

        d0_op(0, 0, 0, 1, 32'h20, 32'h11223344, 4'hF);
        d0_op(0, 0, 0, 1, 32'h20, 32'h0000AA00, 4'h2);
        d0_op(0, 0, 1, 0, 32'h20, 0, 0);
        check("lane", b0.dbus_rdata, 32'h1122AA44);
        d0_op(0, 0, 0, 1, 32'h20, 32'hFFFFFFFF, 4'h0);
        check("w0_resp", 32'(b0.dbus_wresponse), 1);
        d0_op(0, 0, 1, 0, 32'h22, 0, 0);
        check("w0_keep", b0.dbus_rdata, 32'h1122AA44);

        d0_op(0, 0, 0, 1, 32'h40, 32'h12345678, 4'hF);
        d0_op(1, 32'h40, 0, 1, 32'h40, 32'h55555555, 4'hF);
        check("coll_irsp", 32'(b0.ibus_rresponse), 1);
        check("coll_idata", b0.ibus_rdata, 32'h12345678);
        d0_op(0, 0, 1, 1, 32'h40, 32'h66666666, 4'hF);
        check("rw_rdata", b0.dbus_rdata, 32'h55555555);
        check("rw_both", {30'd0, b0.dbus_rresponse, b0.dbus_wresponse}, 32'd3);
        d0_op(0, 0, 1, 0, 32'h40, 0, 0);
        check("rw_after", b0.dbus_rdata, 32'h66666666);
        check("err_clean", 32'(ae0), 0);

        d0_op(0, 0, 0, 1, 32'h0, 32'hCAFEF00D, 4'hF);
        d0_op(0, 0, 1, 0, 32'h2000, 0, 0);
        check("oor_rsp", 32'(b0.dbus_rresponse), 1);
`ifdef RVX_RAM_RESPONDER_RANGE_CHECK_EN
        check("oor_rdata", b0.dbus_rdata, 32'h0);
        check("oor_err", 32'(ae0), 1);
        tick();
        tick();
        check("oor_err_held", 32'(ae0), 1);
`else
        check("wrap_rdata", b0.dbus_rdata, 32'hCAFEF00D);
        check("wrap_err", 32'(ae0), 0);
`endif

        b3.dbus_address = 32'h0;
        b3.dbus_wdata = 32'hA5A5A5A5;
        b3.dbus_wstrobe = 4'hF;
        b3.dbus_wrequest = 1'b1;
        tick();
        b3.dbus_wrequest = 1'b0;
        n = 0;
        while (!b3.dbus_wresponse && n < 20) begin
            tick();
            n++;
        end
        check("w3_lat", 32'(n), 3);
        tick();
        b3.ibus_address = 32'h0;
        b3.ibus_rrequest = 1'b1;
        tick();
        check("f3_k0", 32'(b3.ibus_rresponse), 0);
        tick();
        b3.ibus_rrequest = 1'b0;
        check("f3_k1", 32'(b3.ibus_rresponse), 0);
        tick();
        check("f3_k2", 32'(b3.ibus_rresponse), 0);
        tick();
        check("f3_k3", 32'(b3.ibus_rresponse), 1);
        check("f3_data", b3.ibus_rdata, 32'hA5A5A5A5);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n += int'(b3.ibus_rresponse);
        end
        check("f3_extra", 32'(n), 0);
        check("f3_hold", b3.ibus_rdata, 32'hA5A5A5A5);

        b2.dbus_address = 32'h8;
        b2.dbus_wdata = 32'h13579BDF;
        b2.dbus_wstrobe = 4'hF;
        b2.dbus_wrequest = 1'b1;
        tick();
        b2.dbus_wrequest = 1'b0;
        n = 0;
        while (!b2.dbus_wresponse && n < 20) begin
            tick();
            n++;
        end
        check("w2_lat", 32'(n), 2);
        tick();
        b2.dbus_rrequest = 1'b1;
        tick();
        b2.dbus_rrequest = 1'b0;
        n = 0;
        while (!b2.dbus_rresponse && n < 20) begin
            tick();
            n++;
        end
        check("r2_data", b2.dbus_rdata, 32'h13579BDF);
        tick();
        b2.dbus_wdata = 32'hFFFFFFFF;
        b2.dbus_wrequest = 1'b1;
        tick();
        b2.dbus_wrequest = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("rst2_wresp", 32'(b2.dbus_wresponse), 0);
        check("rst2_rresp", 32'(b2.dbus_rresponse), 0);
        check("rst2_rdata", b2.dbus_rdata, 0);
        check("rst2_irdata", b2.ibus_rdata, 0);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n += int'(b2.dbus_wresponse);
        end
        check("rst2_noresp", 32'(n), 0);
        b2.dbus_rrequest = 1'b1;
        tick();
        b2.dbus_rrequest = 1'b0;
        n = 0;
        while (!b2.dbus_rresponse && n < 20) begin
            tick();
            n++;
        end
        check("rst2_lat", 32'(n), 2);
        check("rst2_keep", b2.dbus_rdata, 32'h13579BDF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
